// File: rtl/gpu_cmd_transmitter.sv
// Host-side master for the GPU 16-bit parallel command bus: serialises command/data words
// onto cmd_data with a divided cmd_clk, honours RDY/#BSY, and turns the bus around for reads.
module gpu_cmd_transmitter #(
    parameter int CLK_DIV       = 4,
    parameter int READY_TIMEOUT = 1024
) (
    input  logic        gpuClock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic [15:0] req_command,
    input  logic [15:0] req_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        timeout_err,
    output logic        busy,
    output logic        cmd_clk,
    output logic        cmd_outputEnable,
    output logic [15:0] cmd_data_out,
    output logic        cmd_data_oe,
    input  logic [15:0] cmd_data_in,
    input  logic        cmd_readyBusy
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int TO_W  = $clog2(READY_TIMEOUT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(READY_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_CMD_LO,
        S_CMD_HI,
        S_DAT_LO,
        S_DAT_HI,
        S_TURN,
        S_RD_LO,
        S_RD_HI,
        S_RECOVER
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_rdy_meta;
    logic               r_rdy_s;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic [15:0]        r_cmd;
    logic [15:0]        r_data;
    logic               r_read;
    logic               r_cmd_clk;
    logic               r_oe;
    logic               r_out_en;
    logic [15:0]        r_data_out;
    logic               r_rsp_valid;
    logic [15:0]        r_rsp_data;
    logic               r_timeout;
    logic               w_accept;
    logic               w_div_done;
    logic               w_timeout;
    logic               w_rd_sample;

    // Handshake: a request transfers on any gpuClock edge where req_valid && req_ready;
    // req_ready is high only in IDLE with reset released, and req_valid may be held across.
    assign req_ready   = (r_state == S_IDLE) && reset;
    assign w_accept    = req_valid && req_ready;
    assign w_div_done  = (r_div_cnt == DIV_LAST);
    assign w_timeout   = (r_state == S_WAIT_RDY) && !r_rdy_s && (r_to_cnt == TO_LAST);
    assign w_rd_sample = (r_state == S_RD_HI) && w_div_done;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_accept) w_state_nxt = S_WAIT_RDY;
            S_WAIT_RDY: begin
                if (r_rdy_s)        w_state_nxt = S_CMD_LO;
                else if (w_timeout) w_state_nxt = S_IDLE;
            end
            S_CMD_LO:   if (w_div_done) w_state_nxt = S_CMD_HI;
            S_CMD_HI:   if (w_div_done) w_state_nxt = r_read ? S_TURN : S_DAT_LO;
            S_DAT_LO:   if (w_div_done) w_state_nxt = S_DAT_HI;
            S_DAT_HI:   if (w_div_done) w_state_nxt = S_IDLE;
            S_TURN:     if (w_div_done) w_state_nxt = S_RD_LO;
            S_RD_LO:    if (w_div_done) w_state_nxt = S_RD_HI;
            S_RD_HI:    if (w_div_done) w_state_nxt = S_RECOVER;
            S_RECOVER:  if (w_div_done) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Pin outputs are registered from the next state so they line up exactly with the state.
    always_ff @(posedge gpuClock) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_rdy_meta  <= 1'b0;
            r_rdy_s     <= 1'b0;
            r_div_cnt   <= '0;
            r_to_cnt    <= '0;
            r_cmd       <= '0;
            r_data      <= '0;
            r_read      <= 1'b0;
            r_cmd_clk   <= 1'b0;
            r_oe        <= 1'b0;
            r_out_en    <= 1'b0;
            r_data_out  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_rdy_meta <= cmd_readyBusy;
            r_rdy_s    <= r_rdy_meta;
            r_state    <= w_state_nxt;

            if (w_state_nxt != r_state) r_div_cnt <= '0;
            else                        r_div_cnt <= r_div_cnt + 1'b1;

            if (r_state != S_WAIT_RDY) r_to_cnt <= '0;
            else                       r_to_cnt <= r_to_cnt + 1'b1;

            if (w_accept) begin
                r_cmd  <= req_command;
                r_data <= req_data;
                r_read <= req_read;
            end

            r_cmd_clk <= w_state_nxt inside {S_CMD_HI, S_DAT_HI, S_RD_HI};
            r_oe      <= w_state_nxt inside {S_CMD_LO, S_CMD_HI, S_DAT_LO, S_DAT_HI};
            r_out_en  <= w_state_nxt inside {S_TURN, S_RD_LO, S_RD_HI};

            // Drive value only moves on LO entry, so it is stable across each LO+HI pair.
            if (r_state == S_WAIT_RDY && w_state_nxt == S_CMD_LO) r_data_out <= r_cmd;
            if (r_state == S_CMD_HI && w_state_nxt == S_DAT_LO)   r_data_out <= r_data;

            r_rsp_valid <= w_rd_sample;
            if (w_rd_sample) r_rsp_data <= cmd_data_in;
            r_timeout <= w_timeout;
        end
    end

    assign busy             = (r_state != S_IDLE);
    assign cmd_clk          = r_cmd_clk;
    assign cmd_data_oe      = r_oe;
    assign cmd_outputEnable = r_out_en;
    assign cmd_data_out     = r_data_out;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_data         = r_rsp_data;
    assign timeout_err      = r_timeout;

endmodule

// File: tb/tb_gpu_cmd_transmitter.sv
// Bench for gpu_cmd_transmitter: a bus monitor plays the GPU side and records what it sees;
// directed and random transactions are scored against expectations derived from the bus protocol.
module tb_gpu_cmd_transmitter;

    localparam int CD = 4;
    localparam int TO = 64;

    logic        gpuClock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_read;
    logic [15:0] req_command;
    logic [15:0] req_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        timeout_err;
    logic        busy;
    logic        cmd_clk;
    logic        cmd_outputEnable;
    logic [15:0] cmd_data_out;
    logic        cmd_data_oe;
    logic [15:0] cmd_data_in;
    logic        cmd_readyBusy;
    logic [15:0] gpu_word;

    gpu_cmd_transmitter #(.CLK_DIV(CD), .READY_TIMEOUT(TO)) dut (
        .gpuClock(gpuClock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
        .req_command(req_command), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .timeout_err(timeout_err), .busy(busy),
        .cmd_clk(cmd_clk), .cmd_outputEnable(cmd_outputEnable),
        .cmd_data_out(cmd_data_out), .cmd_data_oe(cmd_data_oe),
        .cmd_data_in(cmd_data_in), .cmd_readyBusy(cmd_readyBusy)
    );

    always #5 gpuClock = ~gpuClock;

    // GPU only drives the pad while it has been granted the bus.
    assign cmd_data_in = cmd_outputEnable ? gpu_word : 16'hDEAD;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    // ---------------- monitor (sole writer of the observation state) ----------------
    logic [15:0] host_q[$];
    logic [15:0] rsp_q[$];
    int rsp_off_q[$];
    int busy_len_q[$];
    int idle_len_q[$];
    int to_off_q[$];
    int rd_pulses = 0, oe_cycles = 0, oen_cycles = 0, hi_cycles = 0;
    int hi_bad = 0, lo_bad = 0, contention = 0, unstable = 0, both_cnt = 0, to_cnt = 0;
    int busy_run = 0, idle_run = 0, hi_run = 0, lo_run = 0;
    logic p_clk = 1'b0, p_oe = 1'b0, p_busy = 1'b0;
    logic [15:0] p_data = 16'h0;

    always @(negedge gpuClock) begin
        if (cmd_clk === 1'b1 && !p_clk) begin
            if (cmd_data_oe === 1'b1) host_q.push_back(cmd_data_out);
            else if (cmd_outputEnable === 1'b1) rd_pulses++;
            if (lo_run < CD) lo_bad++;
        end
        if (cmd_clk === 1'b0 && p_clk && hi_run != CD) hi_bad++;
        if (cmd_clk === 1'b1) begin
            hi_run = p_clk ? hi_run + 1 : 1;
            lo_run = 0;
            hi_cycles++;
        end else begin
            lo_run = p_clk ? 1 : lo_run + 1;
            hi_run = 0;
        end
        if (busy === 1'b1) begin
            if (!p_busy) begin
                idle_len_q.push_back(idle_run);
                busy_run = 0;
            end else busy_run++;
        end else begin
            if (p_busy) busy_len_q.push_back(busy_run + 1);
            idle_run = p_busy ? 1 : idle_run + 1;
        end
        if (rsp_valid === 1'b1) begin
            rsp_q.push_back(rsp_data);
            rsp_off_q.push_back(busy === 1'b1 ? busy_run : -1);
        end
        if (timeout_err === 1'b1) begin
            to_cnt++;
            to_off_q.push_back(busy === 1'b1 ? -1 : busy_run + 1);
        end
        if (cmd_data_oe === 1'b1 && cmd_outputEnable === 1'b1) contention++;
        if (cmd_data_oe === 1'b1) oe_cycles++;
        if (cmd_outputEnable === 1'b1) oen_cycles++;
        if (rsp_valid === 1'b1 && timeout_err === 1'b1) both_cnt++;
        if (cmd_data_oe === 1'b1 && p_oe && cmd_data_out !== p_data && !(p_clk && cmd_clk === 1'b0))
            unstable++;
        p_clk  = (cmd_clk === 1'b1);
        p_oe   = (cmd_data_oe === 1'b1);
        p_busy = (busy === 1'b1);
        p_data = cmd_data_out;
    end

    // ---------------- comparison helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    int s_host, s_rd, s_oe, s_oen, s_hi, s_hibad, s_lobad, s_cont, s_unst, s_both, s_to, s_rsp, s_busy;

    task automatic snap();
        s_host = host_q.size();   s_rd = rd_pulses;    s_oe = oe_cycles;   s_oen = oen_cycles;
        s_hi = hi_cycles;         s_hibad = hi_bad;    s_lobad = lo_bad;   s_cont = contention;
        s_unst = unstable;        s_both = both_cnt;   s_to = to_cnt;      s_rsp = rsp_q.size();
        s_busy = busy_len_q.size();
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic rd, input logic [15:0] c, input logic [15:0] d, input logic hold);
        int n;
        n = 0;
        req_valid = 1'b1; req_read = rd; req_command = c; req_data = d;
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge gpuClock);
            n++;
        end
        chk1("accept_in_budget", n < 200, 1'b1);
        @(posedge gpuClock);
        @(negedge gpuClock);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge gpuClock);
        while (busy !== 1'b0 && n < budget) begin
            @(negedge gpuClock);
            n++;
        end
        chk1("idle_in_budget", n < budget, 1'b1);
        @(negedge gpuClock);
    endtask

    // Expected bus picture of one transaction, from the protocol: a write shows the host
    // driving command then data (two pulses); a read shows the command pulse, a GPU-driven
    // pulse and a response word. Busy spans one ready-check cycle plus the timed phases.
    task automatic check_txn(input logic rd, input logic [15:0] c, input logic [15:0] d,
                             input logic [15:0] g, input logic chk_len);
        int n;
        exp_q.push_back(c);
        if (!rd) exp_q.push_back(d);
        n = exp_q.size();
        chk("host_word_count", host_q.size() - s_host, n);
        for (int i = 0; i < n; i++) chk16("host_word", host_q[s_host + i], exp_q.pop_front());
        chk("gpu_pulses", rd_pulses - s_rd, rd ? 1 : 0);
        chk("oe_cycles", oe_cycles - s_oe, rd ? 2 * CD : 4 * CD);
        chk("out_en_cycles", oen_cycles - s_oen, rd ? 3 * CD : 0);
        chk("clk_high_len_bad", hi_bad - s_hibad, 0);
        chk("clk_low_len_bad", lo_bad - s_lobad, 0);
        chk("bus_contention", contention - s_cont, 0);
        chk("drive_unstable", unstable - s_unst, 0);
        chk("rsp_and_timeout", both_cnt - s_both, 0);
        chk("timeout_count", to_cnt - s_to, 0);
        chk("rsp_count", rsp_q.size() - s_rsp, rd ? 1 : 0);
        if (rd && rsp_q.size() > s_rsp) begin
            chk16("rsp_data", rsp_q[s_rsp], g);
            if (chk_len) chk("rsp_latency", rsp_off_q[s_rsp], 1 + 5 * CD);
        end
        if (chk_len) begin
            chk("busy_run_count", busy_len_q.size() - s_busy, 1);
            if (busy_len_q.size() > s_busy)
                chk("busy_len", busy_len_q[s_busy], rd ? 1 + 6 * CD : 1 + 4 * CD);
        end
    endtask

    // ---------------- directed sequence ----------------
    logic        rd_r;
    logic [15:0] c_r, d_r, g_r, c2_r, d2_r;
    int          found;

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_read = 1'b0; req_command = '0; req_data = '0;
        cmd_readyBusy = 1'b1; gpu_word = '0;
        repeat (3) @(negedge gpuClock);
        chk1("rst_cmd_clk", cmd_clk, 1'b0);
        chk1("rst_oe", cmd_data_oe, 1'b0);
        chk1("rst_out_en", cmd_outputEnable, 1'b0);
        chk16("rst_data_out", cmd_data_out, 16'h0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk16("rst_rsp_data", rsp_data, 16'h0);
        chk1("rst_timeout", timeout_err, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_req_ready", req_ready, 1'b0);
        reset = 1'b1;
        repeat (4) @(negedge gpuClock);
        chk1("idle_req_ready", req_ready, 1'b1);

        snap(); send(1'b0, 16'h0012, 16'hBEEF, 1'b0); wait_idle(200);
        check_txn(1'b0, 16'h0012, 16'hBEEF, 16'h0, 1'b1);

        gpu_word = 16'hA5C3;
        snap(); send(1'b1, 16'h0081, 16'h0000, 1'b0); wait_idle(200);
        check_txn(1'b1, 16'h0081, 16'h0000, 16'hA5C3, 1'b1);

        for (int i = 0; i < 10; i++) begin
            rd_r = 1'($urandom_range(0, 1));
            c_r = 16'($urandom); d_r = 16'($urandom); g_r = 16'($urandom);
            gpu_word = g_r;
            repeat ($urandom_range(0, 3)) @(negedge gpuClock);
            snap(); send(rd_r, c_r, d_r, 1'b0); wait_idle(200);
            check_txn(rd_r, c_r, d_r, g_r, 1'b1);
        end

        // Ready stall: nothing moves on the bus until the synchronised ready is seen.
        cmd_readyBusy = 1'b0;
        repeat (4) @(negedge gpuClock);
        c_r = 16'($urandom); d_r = 16'($urandom);
        snap(); send(1'b0, c_r, d_r, 1'b0);
        repeat (50) @(negedge gpuClock);
        chk("stall_no_clk", hi_cycles - s_hi, 0);
        chk("stall_no_oe", oe_cycles - s_oe, 0);
        chk1("stall_busy", busy, 1'b1);
        cmd_readyBusy = 1'b1;
        @(negedge gpuClock); chk1("stall_oe_after1", cmd_data_oe, 1'b0);
        @(negedge gpuClock); chk1("stall_oe_after2", cmd_data_oe, 1'b0);
        @(negedge gpuClock); chk1("stall_oe_after3", cmd_data_oe, 1'b1);
        chk1("stall_clk_low_first", cmd_clk, 1'b0);
        wait_idle(200);
        check_txn(1'b0, c_r, d_r, 16'h0, 1'b0);

        // Ready timeout.
        cmd_readyBusy = 1'b0;
        repeat (4) @(negedge gpuClock);
        snap(); send(1'b0, 16'($urandom), 16'($urandom), 1'b0); wait_idle(300);
        chk("to_count", to_cnt - s_to, 1);
        if (to_off_q.size() > 0) chk("to_offset", to_off_q[to_off_q.size() - 1], TO);
        if (busy_len_q.size() > s_busy) chk("to_busy_len", busy_len_q[s_busy], TO);
        chk("to_no_clk", hi_cycles - s_hi, 0);
        chk("to_no_words", host_q.size() - s_host, 0);
        chk("to_no_rsp", rsp_q.size() - s_rsp, 0);
        chk1("to_req_ready", req_ready, 1'b1);
        cmd_readyBusy = 1'b1;
        repeat (4) @(negedge gpuClock);

        // Back-to-back writes with req_valid held.
        c_r = 16'($urandom); d_r = 16'($urandom); c2_r = 16'($urandom); d2_r = 16'($urandom);
        snap();
        send(1'b0, c_r, d_r, 1'b1);
        send(1'b0, c2_r, d2_r, 1'b0);
        wait_idle(300);
        exp_q.push_back(c_r); exp_q.push_back(d_r); exp_q.push_back(c2_r); exp_q.push_back(d2_r);
        chk("b2b_word_count", host_q.size() - s_host, 4);
        for (int i = 0; i < 4; i++) chk16("b2b_word", host_q[s_host + i], exp_q.pop_front());
        chk("b2b_idle_gap", idle_len_q[idle_len_q.size() - 1], 1);
        chk("b2b_busy_runs", busy_len_q.size() - s_busy, 2);
        chk("b2b_oe_cycles", oe_cycles - s_oe, 8 * CD);
        chk("b2b_contention", contention - s_cont, 0);

        // Reset during the data high phase.
        c_r = 16'($urandom); d_r = 16'($urandom);
        snap(); send(1'b0, c_r, d_r, 1'b0);
        found = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge gpuClock);
            if (cmd_clk === 1'b1 && cmd_data_oe === 1'b1 && host_q.size() >= s_host + 2) begin
                found = 1;
                break;
            end
        end
        chk("reach_dat_hi", found, 1);
        reset = 1'b0;
        @(negedge gpuClock);
        chk1("mid_rst_cmd_clk", cmd_clk, 1'b0);
        chk1("mid_rst_oe", cmd_data_oe, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_out_en", cmd_outputEnable, 1'b0);
        chk16("mid_rst_data_out", cmd_data_out, 16'h0);
        chk1("mid_rst_req_ready", req_ready, 1'b0);
        reset = 1'b1;
        repeat (4) @(negedge gpuClock);
        chk("mid_rst_no_rsp", rsp_q.size() - s_rsp, 0);
        chk("mid_rst_no_timeout", to_cnt - s_to, 0);
        c_r = 16'($urandom); d_r = 16'($urandom);
        snap(); send(1'b0, c_r, d_r, 1'b0); wait_idle(200);
        check_txn(1'b0, c_r, d_r, 16'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
